// File: rtl/i2c_slave_intf_pkg.sv
// Shared definitions for the I2C target endpoint: FSM encoding and known addresses.
package i2c_slave_intf_pkg;

    // Default 7-bit address of the AHT10 humidity/temperature sensor.
    localparam logic [6:0] AHT10_ADDR = 7'h38;

    // One-hot state encoding, one bit per protocol phase.
    typedef enum logic [7:0] {
        ST_IDLE     = 8'b0000_0001,
        ST_ADDR     = 8'b0000_0010,
        ST_ADDR_ACK = 8'b0000_0100,
        ST_WR_DATA  = 8'b0000_1000,
        ST_WR_ACK   = 8'b0001_0000,
        ST_RD_DATA  = 8'b0010_0000,
        ST_RD_ACK   = 8'b0100_0000,
        ST_IGNORE   = 8'b1000_0000
    } state_e;

endpackage

// File: rtl/i2c_slave_intf_if.sv
// Bus-side and byte-stream signals of the I2C target, bundled for port lists.
interface i2c_slave_intf_if;

    logic       i2c_scl;
    logic       i2c_sda_i;
    logic       i2c_sda_o;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       addr_hit;
    logic       rw;
    logic       stop_det;
    logic       busy;

    // The target endpoint itself.
    modport slave (
        input  i2c_scl, i2c_sda_i, tx_data,
        output i2c_sda_o, i2c_sda_oe, rx_data, rx_valid, tx_req,
               addr_hit, rw, stop_det, busy
    );

    // Whatever drives the bus and consumes the byte stream.
    modport master (
        output i2c_scl, i2c_sda_i, tx_data,
        input  i2c_sda_o, i2c_sda_oe, rx_data, rx_valid, tx_req,
               addr_hit, rw, stop_det, busy
    );

endinterface

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives edge and bus-condition strobes.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2  // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    input  logic sda,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det_raw
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Synchroniser chains plus one delayed copy for edge detection.
    // NOTE: the chains reset to 1 (idle bus level) so leaving reset never looks like an SCL/SDA edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign sda_lvl      = sda_s;
    assign scl_rise     =  scl_s & ~scl_d;
    assign scl_fall     = ~scl_s &  scl_d;
    // SDA moving while SCL is stably high is a bus condition, not data.
    assign start_det    = scl_s & scl_d &  sda_d & ~sda_s;
    assign stop_det_raw = scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_slave_intf.sv
// I2C target endpoint: address match, byte-stream write path, request-driven read path.
module i2c_slave_intf
    import i2c_slave_intf_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = AHT10_ADDR,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    i2c_slave_intf_if.slave bus
);

    logic sda_lvl;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det_raw;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk          (clk),
        .rst          (rst),
        .scl          (bus.i2c_scl),
        .sda          (bus.i2c_sda_i),
        .sda_lvl      (sda_lvl),
        .scl_rise     (scl_rise),
        .scl_fall     (scl_fall),
        .start_det    (start_det),
        .stop_det_raw (stop_det_raw)
    );

    state_e     state_q,     state_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic       byte_done_q, byte_done_d;  // 8th rise (or ACK rise) seen, waiting for its fall
    logic       sda_oe_q,    sda_oe_d;
    logic       rw_q,        rw_d;
    logic       busy_q,      busy_d;
    logic [7:0] rx_data_q,   rx_data_d;
    logic       rx_valid_q,  rx_valid_d;
    logic       addr_hit_q,  addr_hit_d;
    logic       stop_det_q,  stop_det_d;
    logic       tx_req;
    logic [7:0] shift_in;

    assign shift_in = {shift_q[6:0], sda_lvl};

    // State and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_done_q <= 1'b0;
            sda_oe_q    <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            addr_hit_q  <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            sda_oe_q    <= sda_oe_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            addr_hit_q  <= addr_hit_d;
            stop_det_q  <= stop_det_d;
        end
    end

    // Next-state and next-datapath logic; bus conditions override SCL edges.
    // NOTE: every output of this block is defaulted first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        sda_oe_d    = sda_oe_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        addr_hit_d  = 1'b0;
        stop_det_d  = 1'b0;
        tx_req      = 1'b0;

        if (stop_det_raw) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            busy_d      = 1'b0;
            stop_det_d  = busy_q;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
        end else if (start_det) begin
            // Repeated START keeps busy until the new address is judged.
            state_d     = ST_ADDR;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = '0;
            byte_done_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;

                ST_ADDR: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (shift_in[7:1] == SLAVE_ADDR) begin
                                addr_hit_d  = 1'b1;
                                rw_d        = shift_in[0];
                                busy_d      = 1'b1;
                                byte_done_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = ST_ADDR_ACK;
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        if (!rw_q) begin
                            state_d = ST_WR_DATA;
                        end else begin
                            tx_req   = 1'b1;
                            shift_d  = bus.tx_data;
                            sda_oe_d = ~bus.tx_data[7];
                            state_d  = ST_RD_DATA;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (scl_rise && !byte_done_q) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = shift_in;
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        sda_oe_d    = 1'b1;
                        byte_done_d = 1'b0;
                        state_d     = ST_WR_ACK;
                    end
                end

                ST_WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_WR_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (scl_rise && !byte_done_q) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (byte_done_q) begin
                            sda_oe_d    = 1'b0;
                            byte_done_d = 1'b0;
                            state_d     = ST_RD_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise && !byte_done_q) begin
                        if (sda_lvl) begin
                            state_d = ST_IGNORE;
                        end else begin
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        tx_req      = 1'b1;
                        shift_d     = bus.tx_data;
                        sda_oe_d    = ~bus.tx_data[7];
                        state_d     = ST_RD_DATA;
                    end
                end

                ST_IGNORE: ;

                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.i2c_sda_o  = 1'b0;
    assign bus.i2c_sda_oe = sda_oe_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.tx_req     = tx_req;
    assign bus.addr_hit   = addr_hit_q;
    assign bus.rw         = rw_q;
    assign bus.stop_det   = stop_det_q;
    assign bus.busy       = busy_q;

endmodule
